// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Round-robin arbiter for N requesters. A combinational search
//                picks the winner and a two-state FSM registers the grant. The
//                grant is held until the owner pulses done, withdraws its
//                request, or exceeds MAX_HOLD cycles while another requester
//                is waiting. An X/Z request bit is treated as not requesting.
//                Optional macro RR_ARB_FIXED_PRI_EN switches to fixed
//                priority, where the highest index wins and the pointer is
//                held at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int c_idx_w = $clog2(N);
    localparam int c_cnt_w = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_max = c_cnt_w'(MAX_HOLD - 1);
    localparam logic [c_idx_w-1:0] c_last_id  = c_idx_w'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   w_ptr_nxt;
    logic [c_cnt_w-1:0]   r_hold_cnt;
    logic [c_cnt_w-1:0]   w_hold_nxt;
    logic [N-1:0]         r_gnt;
    logic [N-1:0]         w_gnt_nxt;
    logic                 r_gnt_valid;
    logic                 w_valid_nxt;
    logic [c_idx_w-1:0]   r_gnt_id;
    logic [c_idx_w-1:0]   w_id_nxt;

    logic [N-1:0]         w_req_clean;
    logic                 w_found;
    logic [c_idx_w-1:0]   w_win;
    logic                 w_release;

    // Only a definite 1 counts as a request; X/Z bits read as idle
    always_comb begin
        w_req_clean = '0;
        for (int i = 0; i < N; i++) begin
            w_req_clean[i] = (req[i] === 1'b1);
        end
    end

`ifdef RR_ARB_FIXED_PRI_EN
    // Fixed priority: ascending scan, the last (highest) set bit wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_req_clean[i]) begin
                w_found = 1'b1;
                w_win   = c_idx_w'(i);
            end
        end
    end
`else
    logic [c_idx_w:0] w_pos;

    // Rotating search: first set bit at or above ptr, wrapping past N-1 to 0
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, r_ptr} + (c_idx_w + 1)'(i);
            if (w_pos > (c_idx_w + 1)'(N - 1)) begin
                w_pos = w_pos - (c_idx_w + 1)'(N);
            end
            if (!w_found && w_req_clean[w_pos[c_idx_w-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_pos[c_idx_w-1:0];
            end
        end
    end
`endif

    // Next-state, grant and pointer logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_gnt_valid;
        w_id_nxt    = r_gnt_id;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_id_nxt    = '0;
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = N'(1) << w_win;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = w_win;
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                w_release = done
                         || !w_req_clean[r_gnt_id]
                         || ((r_hold_cnt == c_hold_max) && (|(w_req_clean & ~r_gnt)));
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_id_nxt    = '0;
`ifdef RR_ARB_FIXED_PRI_EN
                    w_ptr_nxt   = '0;
`else
                    w_ptr_nxt   = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + c_idx_w'(1);
`endif
                end else if (r_hold_cnt != c_hold_max) begin
                    w_hold_nxt = r_hold_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_id_nxt    = '0;
            end
        endcase
    end

    // State, pointer, hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_gnt_id    <= w_id_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Directed self-checking bench for rr_arbiter8 (N=8,
//                MAX_HOLD=16). Inputs change 1 time unit after a rising edge,
//                outputs are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;

    int vectors = 0;
    int errors  = 0;

    rr_arbiter8 #(.N(8), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Checks gnt, gnt_valid and gnt_id against an expected grant vector
    task automatic expect_gnt(input string tag, input logic [7:0] exp);
        logic [2:0] id;
        id = '0;
        for (int i = 0; i < 8; i++) begin
            if (exp[i]) id = i[2:0];
        end
        check({tag, ".gnt"},   {24'h0, gnt},       {24'h0, exp});
        check({tag, ".valid"}, {31'h0, gnt_valid}, {31'h0, (exp != 8'h00)});
        check({tag, ".id"},    {29'h0, gnt_id},    {29'h0, id});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        done = 1'b0;
`ifdef RR_ARB_FIXED_PRI_EN
        req = 8'b1001_0010;
        tick; expect_gnt("fx_rst", 8'h00);
        rst = 1'b0;
        tick; expect_gnt("fx_first", 8'h80);
        done = 1'b1;
        tick; expect_gnt("fx_dead", 8'h00);
        done = 1'b0;
        tick; expect_gnt("fx_again", 8'h80);
`else
        // Reset with all requesting
        req = 8'hFF;
        tick; expect_gnt("rst0", 8'h00);
        tick; expect_gnt("rst1", 8'h00);
        rst = 1'b0;
        tick; expect_gnt("first", 8'h01);

        // Rotation 1..7 then back to 0, one dead cycle between grants
        for (int k = 1; k <= 8; k++) begin
            done = 1'b1;
            tick; expect_gnt("rot_dead", 8'h00);
            done = 1'b0;
            tick; expect_gnt("rot_gnt", 8'h01 << (k % 8));
            check("rot_onehot", {31'h0, $onehot(gnt)}, 32'h1);
        end

        // Wrap search: grant 5, then ptr=6 with req=0000_0101
        done = 1'b1;
        tick; expect_gnt("wr_dead0", 8'h00);
        done = 1'b0;
        req  = 8'h20;
        tick; expect_gnt("wr_g5", 8'h20);
        req  = 8'b0000_0101;
        tick; expect_gnt("wr_rel5", 8'h00);
        tick; expect_gnt("wr_g0", 8'h01);
        done = 1'b1;
        tick; expect_gnt("wr_dead1", 8'h00);
        done = 1'b0;
        tick; expect_gnt("wr_g2", 8'h04);

        // Timeout: requester 0 vs 1 waiting, release after 16 grant cycles
        req = 8'h03;
        tick; expect_gnt("to_rel2", 8'h00);
        tick; expect_gnt("to_g0", 8'h01);
        for (int c = 1; c < 16; c++) begin
            tick; expect_gnt("to_hold", 8'h01);
        end
        tick; expect_gnt("to_rel", 8'h00);
        tick; expect_gnt("to_g1", 8'h02);

        // Lone requester held indefinitely
        req = 8'h01;
        tick; expect_gnt("lone_rel1", 8'h00);
        tick; expect_gnt("lone_g0", 8'h01);
        for (int c = 0; c < 45; c++) begin
            tick; check("lone_hold", {24'h0, gnt}, 32'h01);
        end

        // Withdraw during grant to 3
        req = 8'h08;
        tick; expect_gnt("wd_rel0", 8'h00);
        tick; expect_gnt("wd_g3", 8'h08);
        tick; expect_gnt("wd_keep3", 8'h08);
        req = 8'h00;
        tick; expect_gnt("wd_drop", 8'h00);
        tick; expect_gnt("wd_idle", 8'h00);

        // X/Z on req must not grant
        req = 8'bx;
        tick; expect_gnt("x0", 8'h00);
        tick; expect_gnt("x1", 8'h00);

        // Reset mid-grant, then restart from index 0
        req = 8'hFF;
        tick; expect_gnt("rm_g4", 8'h10);
        rst = 1'b1;
        tick; expect_gnt("rm_rst", 8'h00);
        rst = 1'b0;
        tick; expect_gnt("rm_g0", 8'h01);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters. Default N=8 matches the 8-bit priority encoder datapath.
- Registered state machine with a rotating priority pointer. The priority search itself is combinational.
- Produces a registered one-hot grant plus its binary index, holds the grant until release, and enforces a maximum hold time so no requester starves.

Parameters:
- N, 8, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive grant cycles while another requester is waiting (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  N  request vector, one bit per requester, level-sensitive.
- done  input  1  single-cycle pulse from the current owner releasing the grant; ignored in IDLE.
- gnt  output  N  registered grant vector; one-hot or all-zero.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_id  output  $clog2(N)  binary index of the granted requester; 0 when gnt_valid=0.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=0, gnt_valid=0, gnt_id=0.
  - rst overrides everything, including mid-grant; the grant drops on the edge where rst is sampled.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE with outputs zero.
  - Otherwise select winner w = first set req bit searching upward from index ptr, wrapping N-1 -> 0.
  - At the next edge: gnt=1<<w, gnt_id=w, gnt_valid=1, hold_cnt=0, go to GRANT.
  - Latency is one cycle from req sampled to gnt visible.
- GRANT:
  - Release occurs when any of these holds at an edge:
    - done=1;
    - req[gnt_id]=0 (requester withdrew);
    - hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0, i.e. timeout with another requester waiting.
  - On release: gnt=0, gnt_valid=0, gnt_id=0, ptr=(gnt_id+1) mod N, go to IDLE.
  - There is exactly one dead cycle with gnt=0 between consecutive grants.
  - Otherwise stay in GRANT. hold_cnt increments and saturates at MAX_HOLD-1. With no other requester waiting, the grant is held indefinitely.
- Simultaneous events:
  - done together with timeout counts as a single release; ptr advances once.
  - New request bits arriving during GRANT have no effect until the next IDLE evaluation.
- Invariants, every cycle after reset:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt is a subset of the req value sampled when the grant was issued.
  - Outputs are never X or Z after reset, including when req carries X/Z. An X/Z bit is treated as 0 by the search; a bench may drive req=x, and the required result is gnt=0.
- Width rule: ptr and gnt_id are $clog2(N) bits. Wrap uses an explicit compare to N-1, never relying on natural overflow, so non-power-of-2 N is correct.

Optional Feature:
- Macro: RR_ARB_FIXED_PRI_EN.
- Defined:
  - ptr is ignored (held at 0). IDLE always grants the highest-index set req bit, matching priority-encoder ordering (MSB wins).
  - Timeout release still applies; after release the same requester may win again if it is still highest.
- Undefined: round-robin behaviour exactly as specified above.

Test Plan:
- Reset and idle: rst=1 for 2 cycles with req=8'hFF, then rst=0 -> gnt=0 during reset. First grant gnt=8'h01, gnt_id=0 one cycle after release of reset.
- Rotation:
  - Stimulus: req=8'hFF held, done pulsed one cycle after each grant.
  - Required: grant order 0,1,2,...,7,0, with gnt=0 for exactly one cycle between grants.
  - Required: $onehot(gnt) holds whenever gnt_valid=1.
- Wrap search: ptr=6 (after granting 5), req=8'b0000_0101 -> next grant gnt_id=0, then after done gnt_id=2.
- Timeout:
  - Setup: req=8'h03, requester 0 granted, no done.
  - Required: release after exactly MAX_HOLD=16 grant cycles, then gnt=8'h02.
  - With req=8'h01 only, the grant is held more than 40 cycles.
- Withdraw, X and reset mid-grant:
  - Withdraw: during a grant to 3, req[3]->0 -> gnt=0 at the next edge.
  - X input: drive req=8'bx -> gnt=0 and never X/Z.
  - Reset mid-grant: rst=1 during a grant -> gnt=0, and the next grant starts from index 0.
- RR_ARB_FIXED_PRI_EN build: req=8'b1001_0010 -> gnt=8'h80. After done with req unchanged, gnt=8'h80 again.
